grid_letter_store: RTL and testbench

- Consumer of the cursor position (highlightX/highlightY) produced by the crossword cursor block, and of the same USB HID keycode stream.
- Decodes cursor pixel coordinates back to a 5x5 cell index and owns the letter contents of the grid.
- Commits typed letters and backspaces into the indexed cell.
- Serves a registered read port to the VGA text renderer.
- Publishes fill count, grid-full and a write strobe for downstream answer-check logic.

---
 rtl/grid_letter_store_if.sv | 24 ++
 rtl/grid_letter_store.sv | 145 ++++++++++++++
 tb/tb_grid_letter_store.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/grid_letter_store_if.sv
// Signal bundle between the crossword cursor/keyboard side, the letter store,
// the VGA text renderer and the answer-check logic.
interface grid_letter_store_if;
   logic [7:0] keycode;
   logic [9:0] highlight_x;
   logic [9:0] highlight_y;
   logic [4:0] rd_addr;
   logic [4:0] rd_data;
   logic       wr_pulse;
   logic [4:0] wr_addr;
   logic [4:0] filled_count;
   logic       grid_full;
   logic       pos_valid;

   modport slave (
      input  keycode, highlight_x, highlight_y, rd_addr,
      output rd_data, wr_pulse, wr_addr, filled_count, grid_full, pos_valid
   );

   modport master (
      output keycode, highlight_x, highlight_y, rd_addr,
      input  rd_data, wr_pulse, wr_addr, filled_count, grid_full, pos_valid
   );
endinterface

// File: rtl/grid_letter_store.sv
// 5x5 crossword letter store: decodes the cursor pixel position to a cell,
// commits typed letters/backspaces once per key press, serves a renderer read port.
module grid_letter_store #(
   parameter int X_ORIGIN   = 4,
   parameter int Y_ORIGIN   = 80,
   parameter int CELL_PITCH = 80,
   parameter int GRID_DIM   = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   grid_letter_store_if.slave bus
);

   // state   | meaning
   // IDLE    | armed, waiting for a non-zero keycode
   // COMMIT  | single cycle: write captured value into captured cell
   // RELEASE | waiting for keycode == 0 before re-arming
   typedef enum logic [1:0] {IDLE, COMMIT, RELEASE} state_t;

   localparam int NCELL = GRID_DIM * GRID_DIM;

   state_t     state_q;
   logic [4:0] cell_q [NCELL];
   logic [2:0] row_q, col_q;
   logic       pos_valid_q;
   logic [4:0] wr_idx_q, wr_val_q;
   logic [4:0] wr_addr_q;
   logic       wr_pulse_q;
   logic [4:0] count_q, count_d;
   logic       grid_full_q;
   logic [4:0] rd_data_q;

   logic [9:0] dx, dy;
   logic [2:0] row_d, col_d;
   logic       row_hit, col_hit, pos_valid_d;
   logic [4:0] cell_idx;
   logic       key_nz, is_letter, is_bksp;
   logic [4:0] letter_val, old_val;

   // Underflowed subtractions are rejected by the >= guards, not by the chain.
   always_comb begin
      dx      = bus.highlight_x - 10'(X_ORIGIN);
      dy      = bus.highlight_y - 10'(Y_ORIGIN);
      row_d   = '0;
      col_d   = '0;
      row_hit = 1'b0;
      col_hit = 1'b0;
      for (int i = 0; i < GRID_DIM; i++) begin
         if (dx == 10'(i * CELL_PITCH)) begin
            col_d   = 3'(i);
            col_hit = 1'b1;
         end
         if (dy == 10'(i * CELL_PITCH)) begin
            row_d   = 3'(i);
            row_hit = 1'b1;
         end
      end
      pos_valid_d = (bus.highlight_x >= 10'(X_ORIGIN)) && (bus.highlight_y >= 10'(Y_ORIGIN))
                    && col_hit && row_hit;
   end

   always_comb begin
      cell_idx   = 5'(row_q) * 5'd5 + 5'(col_q);
      key_nz     = (bus.keycode != 8'h00);
      is_letter  = (bus.keycode >= 8'h04) && (bus.keycode <= 8'h1D);
      is_bksp    = (bus.keycode == 8'h2A);
      letter_val = 5'(bus.keycode - 8'd3);
      old_val    = cell_q[wr_idx_q];
      count_d    = count_q;
      if ((old_val == 5'd0) && (wr_val_q != 5'd0)) begin
         count_d = count_q + 5'd1;
      end else if ((old_val != 5'd0) && (wr_val_q == 5'd0)) begin
         count_d = count_q - 5'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_q       <= '0;
         col_q       <= '0;
         pos_valid_q <= 1'b0;
      end else begin
         row_q       <= row_d;
         col_q       <= col_d;
         pos_valid_q <= pos_valid_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RELEASE;
         for (int i = 0; i < NCELL; i++) cell_q[i] <= '0;
         wr_idx_q    <= '0;
         wr_val_q    <= '0;
         wr_addr_q   <= '0;
         wr_pulse_q  <= 1'b0;
         count_q     <= '0;
         grid_full_q <= 1'b0;
      end else begin
         wr_pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (key_nz) begin
                  if ((is_letter || is_bksp) && pos_valid_q) begin
                     wr_idx_q <= cell_idx;
                     wr_val_q <= is_letter ? letter_val : 5'd0;
                     state_q  <= COMMIT;
                  end else begin
                     state_q  <= RELEASE;
                  end
               end
            end
            COMMIT: begin
               cell_q[wr_idx_q] <= wr_val_q;
               count_q          <= count_d;
               grid_full_q      <= (count_d == 5'(NCELL));
               wr_addr_q        <= wr_idx_q;
               wr_pulse_q       <= 1'b1;
               state_q          <= RELEASE;
            end
            RELEASE: begin
               if (!key_nz) state_q <= IDLE;
            end
            default: state_q <= RELEASE;
         endcase
      end
   end

   // Non-blocking read of the array gives read-before-write against COMMIT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= (bus.rd_addr < 5'(NCELL)) ? cell_q[bus.rd_addr] : 5'd0;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.wr_pulse     = wr_pulse_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.filled_count = count_q;
   assign bus.grid_full    = grid_full_q;
   assign bus.pos_valid    = pos_valid_q;

endmodule

// File: tb/tb_grid_letter_store.sv
// Directed bench for grid_letter_store: a cell/count model pushes expected
// commits to a queue that a wr_pulse monitor pops and checks.
module tb_grid_letter_store;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   grid_letter_store_if bus();

   grid_letter_store dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      int addr;
      int count;
      bit full;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_cells[25];
   int   exp_count = 0;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit decode(input int x, input int y, output int idx);
      int c, r;
      idx = 0;
      if (x < 4 || y < 80) return 1'b0;
      if (((x - 4) % 80) != 0 || ((y - 80) % 80) != 0) return 1'b0;
      c = (x - 4) / 80;
      r = (y - 80) / 80;
      if (c > 4 || r > 4) return 1'b0;
      idx = r * 5 + c;
      return 1'b1;
   endfunction

   task automatic model_commit(input int idx, input int nv);
      exp_t e;
      if (exp_cells[idx] == 0 && nv != 0) exp_count++;
      else if (exp_cells[idx] != 0 && nv == 0) exp_count--;
      exp_cells[idx] = nv;
      e.addr  = idx;
      e.count = exp_count;
      e.full  = (exp_count == 25);
      sb.push_back(e);
   endtask

   task automatic model_reset();
      foreach (exp_cells[i]) exp_cells[i] = 0;
      exp_count = 0;
   endtask

   task automatic press(input logic [7:0] key, input int x, input int y, input int hold);
      int idx;
      bit v;
      bus.highlight_x = 10'(x);
      bus.highlight_y = 10'(y);
      cyc(2);
      v = decode(x, y, idx);
      chk("pos_valid", 10'(bus.pos_valid), 10'(v));
      if (v && ((key >= 8'h04 && key <= 8'h1D) || key == 8'h2A))
         model_commit(idx, (key == 8'h2A) ? 0 : int'(key) - 3);
      bus.keycode = key;
      cyc(hold);
      bus.keycode = 8'h00;
      cyc(3);
   endtask

   task automatic check_cell(input int idx);
      bus.rd_addr = 5'(idx);
      cyc(1);
      chk($sformatf("cell%0d", idx), 10'(bus.rd_data), 10'(exp_cells[idx]));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.wr_pulse === 1'b1) begin
         n_cmp++;
         assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_wr_pulse: observed pulse at wr_addr %0d expected none", bus.wr_addr);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_addr", 10'(bus.wr_addr), 10'(e.addr));
            chk("filled_count", 10'(bus.filled_count), 10'(e.count));
            chk("grid_full", 10'(bus.grid_full), 10'(e.full));
         end
      end
   end

   initial begin
      bus.keycode     = 8'h00;
      bus.highlight_x = 10'd4;
      bus.highlight_y = 10'd80;
      bus.rd_addr     = 5'd0;
      model_reset();
      cyc(2);
      chk("rst_rd_data", 10'(bus.rd_data), 10'd0);
      chk("rst_wr_pulse", 10'(bus.wr_pulse), 10'd0);
      chk("rst_wr_addr", 10'(bus.wr_addr), 10'd0);
      chk("rst_filled", 10'(bus.filled_count), 10'd0);
      chk("rst_full", 10'(bus.grid_full), 10'd0);
      chk("rst_pos_valid", 10'(bus.pos_valid), 10'd0);
      rst = 1'b0;
      cyc(2);

      // 1: held key yields one write
      press(8'h04, 4, 80, 10);
      check_cell(0);

      // 2: corner cell, then unaligned and underflow cursors
      press(8'h1D, 324, 400, 3);
      check_cell(24);
      press(8'h1D, 325, 400, 3);
      check_cell(24);
      press(8'h05, 0, 80, 2);
      check_cell(0);

      // 3: overwrite, backspace, backspace on blank
      press(8'h05, 324, 400, 2);
      check_cell(24);
      chk("count_overwrite", 10'(bus.filled_count), 10'(exp_count));
      press(8'h2A, 324, 400, 2);
      check_cell(24);
      chk("count_bksp", 10'(bus.filled_count), 10'(exp_count));
      press(8'h2A, 324, 400, 2);
      chk("count_bksp_blank", 10'(bus.filled_count), 10'(exp_count));

      // 4: fill the grid, then one backspace
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            press(8'h04, 4 + 80 * c, 80 + 80 * r, 1);
      chk("full_count", 10'(bus.filled_count), 10'd25);
      chk("full_flag", 10'(bus.grid_full), 10'd1);
      bus.rd_addr = 5'd30;
      cyc(1);
      chk("rd_oob", 10'(bus.rd_data), 10'd0);
      check_cell(13);
      press(8'h2A, 164, 240, 1);
      chk("unfull_count", 10'(bus.filled_count), 10'd24);
      chk("unfull_flag", 10'(bus.grid_full), 10'd0);

      // 5: arrow ignored; key held through reset is not accepted
      press(8'h4F, 4, 80, 2);
      bus.keycode = 8'h04;
      rst = 1'b1;
      model_reset();
      cyc(2);
      rst = 1'b0;
      cyc(6);
      chk("held_no_write", 10'(bus.filled_count), 10'd0);
      bus.keycode = 8'h00;
      cyc(2);
      press(8'h04, 4, 80, 2);
      check_cell(0);

      // 6: read and commit to cell 7 in the same cycle
      bus.rd_addr     = 5'd7;
      bus.highlight_x = 10'd164;
      bus.highlight_y = 10'd160;
      cyc(2);
      model_commit(7, 3);
      bus.keycode = 8'h06;
      cyc(2);
      chk("rbw_old", 10'(bus.rd_data), 10'd0);
      cyc(1);
      chk("rbw_new", 10'(bus.rd_data), 10'd3);
      bus.keycode = 8'h00;
      cyc(5);

      chk("sb_drained", 10'(sb.size()), 10'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
